// File: rtl/sample_averager.sv
// Windowed averager: accumulates 2^LOG2N gated samples and presents sum and mean
// through a valid/ready result register with a sticky overrun flag.
module sample_averager #(
    parameter int unsigned BW    = 3,
    parameter int unsigned LOG2N = 2
) (
    input  logic                  clk,
    input  logic                  rstx,
    input  logic                  data_is_signed,
    input  logic                  clear,
    input  logic                  data_in_valid,
    input  logic [BW-1:0]         data_in,
    input  logic                  mean_ready,
    output logic                  mean_valid,
    output logic [BW-1:0]         mean,
    output logic [BW+LOG2N-1:0]   sum,
    output logic                  overrun,
    output logic [LOG2N-1:0]      sample_cnt
);

    localparam int unsigned SW = BW + LOG2N;

    logic [SW-1:0]    acc_q, acc_d;
    logic [LOG2N-1:0] cnt_q, cnt_d;
    logic [SW-1:0]    sum_q, sum_d;
    logic [BW-1:0]    mean_q, mean_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;

    logic [SW-1:0]    ext_sample;
    logic [SW-1:0]    new_sum;
    logic             complete;
    logic             transfer;

    assign ext_sample = {{LOG2N{data_is_signed & data_in[BW-1]}}, data_in};
    assign new_sum    = acc_q + ext_sample;
    assign complete   = data_in_valid & (&cnt_q);
    assign transfer   = valid_q & mean_ready;

    always_comb begin
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        sum_d     = sum_q;
        mean_d    = mean_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (clear) begin
            acc_d     = '0;
            cnt_d     = '0;
            sum_d     = '0;
            mean_d    = '0;
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end else begin
            if (transfer) begin
                valid_d = 1'b0;
            end
            if (data_in_valid) begin
                acc_d = new_sum;
                cnt_d = cnt_q + 1'b1;
            end
            if (complete) begin
                acc_d   = '0;
                sum_d   = new_sum;
                // Low BW bits of sum >> LOG2N are the top BW bits of the SW-bit sum,
                // identical for arithmetic and logical shifts.
                mean_d  = new_sum[SW-1:LOG2N];
                valid_d = 1'b1;
                if (valid_q && !mean_ready) begin
                    overrun_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstx) begin
        if (!rstx) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            sum_q     <= '0;
            mean_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            sum_q     <= sum_d;
            mean_q    <= mean_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign mean_valid = valid_q;
    assign mean       = mean_q;
    assign sum        = sum_q;
    assign overrun    = overrun_q;
    assign sample_cnt = cnt_q;

endmodule

// File: doc/sample_averager.md
# sample_averager

Windowed averaging stage that sits directly downstream of the noise gate. It consumes the gated sample stream, accumulates a fixed window of 2^LOG2N samples, and presents the window sum and mean through a valid/ready output register. Downstream consumers (register file / host readout) read one result per window. A sticky overrun flag records any result lost to back-pressure.

## Interface
- BW, default 3: sample width in bits, same as the noise-gate data width.
- LOG2N, default 2: log2 of window length; window N = 2^LOG2N samples; legal range 1..8.

- clk  input  1  clock.
- rstx  input  1  reset, asynchronous, active-low.
- data_is_signed  input  1  1 = samples are two's complement, 0 = unsigned; quasi-static.
- clear  input  1  synchronous clear of window state, result and flags.
- data_in_valid  input  1  sample strobe, from noise-gate data_out_valid.
- data_in  input  BW  sample, from noise-gate data_out.
- mean_ready  input  1  consumer accepts result this cycle.
- mean_valid  output  1  result register holds an unconsumed result.
- mean  output  BW  window mean.
- sum  output  BW+LOG2N  full window sum.
- overrun  output  1  sticky; at least one result was overwritten before consumption.
- sample_cnt  output  LOG2N  samples accepted in the current window so far.

## Operation
- Reset values: mean_valid=0, mean=0, sum=0, overrun=0, sample_cnt=0, internal accumulator=0.
- Extension: each accepted sample is extended to BW+LOG2N bits: sign-extended when data_is_signed=1, zero-extended when 0. The extension uses data_is_signed as sampled in the accepting cycle. Changing data_is_signed mid-window gives a mixed result; software issues clear after a change.
- Accumulate: on data_in_valid=1, acc <= acc + ext(data_in) and sample_cnt <= sample_cnt+1, wrapping naturally at N.
- Completion: when data_in_valid=1 and sample_cnt=N-1:
  - sum <= acc + ext(data_in).
  - mean <= that value arithmetically shifted right by LOG2N when signed, logically when unsigned. Take the low BW bits. Rounding is toward minus infinity.
  - mean_valid <= 1.
  - acc <= 0 and sample_cnt <= 0.
- The sum width BW+LOG2N cannot overflow for N samples, so no saturation is needed.
- Handshake: a result transfers on a cycle where mean_valid=1 and mean_ready=1. After a transfer without a simultaneous completion, mean_valid <= 0. mean and sum hold their value until the next completion, including after transfer.
- Overrun: a completion while mean_valid=1 and mean_ready=0 sets overrun <= 1. The new result overwrites mean/sum and mean_valid stays 1.
- Completion and transfer in the same cycle: the old result is consumed, the new result loads, mean_valid stays 1, and overrun is unchanged.
- Clear: clear=1 has priority over every other action in that cycle. It zeroes acc, sample_cnt, mean, sum, mean_valid and overrun. A sample presented with clear=1 is dropped. Clear is the only way to drop overrun other than reset.
- mean_ready while mean_valid=0 has no effect.

## Timing
- All state is updated on posedge clk, with asynchronous reset on negedge rstx.
- Latency: the completing sample is accepted at edge k. sum, mean and mean_valid are updated at edge k, i.e. visible in the cycle after data_in_valid is asserted.
- Throughput: one sample per cycle. With back-to-back samples, one result is produced every N cycles.
- Outputs are driven from registers only, with no combinational path from any input to any output.
- mean_ready may be held high continuously, giving single-cycle mean_valid pulses.
- rstx asserted mid-window discards the partial window. After release, accumulation starts from sample 0.

## Test plan
- Unsigned, BW=3, LOG2N=2:
  - Samples 1,2,3,4 with mean_ready=1 -> one cycle after the 4th sample: mean_valid=1, sum=10, mean=2. The next cycle: mean_valid=0.
  - Samples 7,7,7,7 -> sum=28, mean=7.
- Signed, BW=3, LOG2N=2:
  - Samples -4,-4,-4,-3 (100,100,100,101) -> sum=-15 (5'b10001), mean=-4 (3'b100).
  - Samples 3,0,0,0 -> sum=3, mean=0.
- Back-pressure:
  - mean_ready=0; feed two full windows (1,1,1,1 then 2,2,2,2) -> after the second window: mean=2, sum=8, mean_valid=1, overrun=1.
  - Then mean_ready=1 for one cycle -> mean_valid=0, overrun stays 1.
  - Then clear -> overrun=0.
- Simultaneous transfer and completion: hold a pending result, assert mean_ready on the same cycle the 4th sample of the next window arrives -> mean_valid stays 1, the new mean loads, overrun=0.
- Clear mid-window: send 2 samples, pulse clear with data_in_valid=1 -> sample_cnt=0 and the sample is dropped. The next 4 samples alone form the window, with the correct sum.
- Reset mid-window: assert rstx=0 asynchronously between edges after 3 samples -> all outputs are immediately 0. After release, a full 4-sample window produces exactly one result.
